count_one_arbiter: RTL and testbench

COUNT_ONE_ARBITER -- requirements
Module: count_one_arbiter

---
 rtl/count_one_arbiter.sv | 141 ++++++++++++++
 tb/tb_count_one_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/count_one_arbiter.sv
// Round-robin arbiter that grants one serial stream at a time and counts accepted
// bits that leave a "two or more consecutive ones" Moore detector in its S2 state.
module count_one_arbiter #(
    parameter int N       = 4,
    parameter int MAX_LEN = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N-1:0]                 req,
    input  logic [N-1:0]                 bit_in,
    input  logic [N-1:0]                 bit_valid,
    output logic [N-1:0]                 gnt,
    output logic                         det,
    output logic [$clog2(MAX_LEN+1)-1:0] det_cnt,
    output logic                         done,
    output logic [$clog2(N)-1:0]         done_id
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(MAX_LEN+1);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} ctrl_t;
    typedef enum logic [1:0] {S0, S1, S2} det_t;

    ctrl_t           state_reg, state_next;
    det_t            det_state_reg, det_state_next;
    logic [N-1:0]    gnt_reg, gnt_next;
    logic [IW-1:0]   g_reg, g_next;
    logic [IW-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [IW-1:0]   done_id_reg, done_id_next;
    logic [CW-1:0]   det_cnt_reg, det_cnt_next;
    logic [CW-1:0]   len_reg, len_next;

    // Candidate index for each round-robin offset from rr_ptr, wrapped modulo N.
    logic [IW:0]     cand_sum [N];
    logic [IW-1:0]   cand_idx [N];
    logic [IW-1:0]   win_idx;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            assign cand_sum[gi] = {1'b0, rr_ptr_reg} + (IW+1)'(gi);
            assign cand_idx[gi] = (cand_sum[gi] >= (IW+1)'(N))
                                ? IW'(cand_sum[gi] - (IW+1)'(N))
                                : cand_sum[gi][IW-1:0];
        end
    endgenerate

    // Scan from the largest offset down so the smallest offset with a request wins.
    always_comb begin
        win_idx = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (req[cand_idx[i]]) begin
                win_idx = cand_idx[i];
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        det_state_next = det_state_reg;
        gnt_next       = gnt_reg;
        g_next         = g_reg;
        rr_ptr_next    = rr_ptr_reg;
        done_id_next   = done_id_reg;
        det_cnt_next   = det_cnt_reg;
        len_next       = len_reg;

        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next        = STREAM;
                    g_next            = win_idx;
                    gnt_next          = '0;
                    gnt_next[win_idx] = 1'b1;
                    det_state_next    = S0;
                    det_cnt_next      = '0;
                    len_next          = '0;
                end
            end
            STREAM: begin
                if (!req[g_reg]) begin
                    state_next   = DONE;
                    gnt_next     = '0;
                    done_id_next = g_reg;
                end else if (bit_valid[g_reg]) begin
                    if (bit_in[g_reg]) begin
                        det_state_next = (det_state_reg == S0) ? S1 : S2;
                    end else begin
                        det_state_next = S0;
                    end
                    if (bit_in[g_reg] && det_state_reg != S0) begin
                        det_cnt_next = det_cnt_reg + CW'(1);
                    end
                    len_next = len_reg + CW'(1);
                    // The bit that fills the burst is counted, then the burst closes.
                    if (len_reg == CW'(MAX_LEN - 1)) begin
                        state_next   = DONE;
                        gnt_next     = '0;
                        done_id_next = g_reg;
                    end
                end
            end
            DONE: begin
                state_next  = IDLE;
                rr_ptr_next = (g_reg == IW'(N - 1)) ? '0 : g_reg + IW'(1);
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            det_state_reg <= S0;
            gnt_reg       <= '0;
            g_reg         <= '0;
            rr_ptr_reg    <= '0;
            done_id_reg   <= '0;
            det_cnt_reg   <= '0;
            len_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            det_state_reg <= det_state_next;
            gnt_reg       <= gnt_next;
            g_reg         <= g_next;
            rr_ptr_reg    <= rr_ptr_next;
            done_id_reg   <= done_id_next;
            det_cnt_reg   <= det_cnt_next;
            len_reg       <= len_next;
        end
    end

    assign gnt     = gnt_reg;
    assign det     = (det_state_reg == S2);
    assign det_cnt = det_cnt_reg;
    assign done    = (state_reg == DONE);
    assign done_id = done_id_reg;

endmodule

// File: tb/tb_count_one_arbiter.sv
// Directed bench for count_one_arbiter (N=4, MAX_LEN=16) with hand-computed expectations.
module tb_count_one_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] bit_in;
    logic [3:0] bit_valid;
    logic [3:0] gnt;
    logic       det;
    logic [4:0] det_cnt;
    logic       done;
    logic [1:0] done_id;

    int n_checks = 0;
    int n_pass   = 0;

    count_one_arbiter #(.N(4), .MAX_LEN(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .gnt       (gnt),
        .det       (det),
        .det_cnt   (det_cnt),
        .done      (done),
        .done_id   (done_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        int glen;
        int exp_id;

        rst_n = 1'b0; req = '0; bit_in = '0; bit_valid = '0;
        tick(); tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_det", det, 0);
        chk("rst_cnt", det_cnt, 0);
        chk("rst_done", done, 0);
        chk("rst_done_id", done_id, 0);

        // Requester 0, bits 1,1,1,0
        rst_n = 1'b1; req = 4'b0001; bit_valid = 4'b0001; bit_in = 4'b0001;
        tick(); chk("b0_gnt1", gnt, 4'b0001);
        tick(); chk("b0_det_b1", det, 0);  chk("b0_gnt2", gnt, 4'b0001);
        tick(); chk("b0_det_b2", det, 1);  chk("b0_gnt3", gnt, 4'b0001);
        tick(); chk("b0_cnt_b3", det_cnt, 2); chk("b0_gnt4", gnt, 4'b0001);
        bit_in = 4'b0000;
        tick(); chk("b0_det_b4", det, 0);  chk("b0_cnt_b4", det_cnt, 2); chk("b0_gnt5", gnt, 4'b0001);
        req = 4'b0000;
        tick(); chk("b0_done", done, 1); chk("b0_done_id", done_id, 0); chk("b0_gnt_off", gnt, 0);
        chk("b0_cnt_hold", det_cnt, 2);
        tick(); chk("b0_idle_done", done, 0); chk("b0_idle_cnt", det_cnt, 2);

        // Requester 2, valid toggling; requester 0 valid with a 0 bit must be ignored
        req = 4'b0100; bit_in = 4'b0100; bit_valid = 4'b0100;
        tick(); chk("b2_gnt", gnt, 4'b0100); chk("b2_cnt_clr", det_cnt, 0); chk("b2_det_clr", det, 0);
        tick(); chk("b2_det_v1", det, 0);
        bit_valid = 4'b0001;
        tick(); chk("b2_det_nv", det, 0);
        bit_valid = 4'b0100;
        tick(); chk("b2_det_v2", det, 1); chk("b2_cnt_v2", det_cnt, 1);
        bit_valid = 4'b0001;
        tick(); chk("b2_det_hold", det, 1); chk("b2_cnt_hold", det_cnt, 1);
        req = 4'b0000;
        tick(); chk("b2_done", done, 1); chk("b2_done_id", done_id, 2);
        tick();

        // Requester 3, pattern 1,0,1,1,0,1,1,1 then reset mid-burst
        req = 4'b1000; bit_valid = 4'b1000;
        tick(); chk("b3_gnt", gnt, 4'b1000);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] pat;
            pat = 8'b1110_1101;
            bit_in = {pat[i], 3'b000};
            tick();
        end
        chk("pat_cnt", det_cnt, 3); chk("pat_det", det, 1); chk("pat_gnt", gnt, 4'b1000);
        rst_n = 1'b0;
        tick(); chk("mrst_gnt", gnt, 0); chk("mrst_det", det, 0); chk("mrst_cnt", det_cnt, 0);
        chk("mrst_done", done, 0);
        rst_n = 1'b1; req = 4'b1001;
        tick(); chk("mrst_regnt", gnt, 4'b0001); chk("mrst_nodone", done, 0);
        req = 4'b1000;
        tick(); chk("mrst_done_id", done_id, 0); chk("mrst_done2", done, 1);
        tick();

        // Only requester 3 re-requesting
        for (int k = 0; k < 2; k++) begin
            req = 4'b1000; bit_valid = 4'b0000;
            tick(); chk("r3_gnt", gnt, 4'b1000);
            req = 4'b0000;
            tick(); chk("r3_done_id", done_id, 3); chk("r3_done", done, 1);
            req = 4'b1000;
            tick(); chk("r3_gap", gnt, 0);
            req = 4'b0000;
        end

        // All requesting, full-length bursts: order 0,1,2,3,0
        req = 4'b1111; bit_valid = 4'b1111; bit_in = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_id = k % 4;
            tick(); chk("rr_gnt", gnt, 32'(1) << exp_id);
            glen = 1;
            while (gnt != 0 && glen < 40) begin
                tick();
                if (gnt != 0) glen++;
            end
            chk("rr_len", glen, 16);
            chk("rr_done", done, 1);
            chk("rr_done_id", done_id, exp_id);
            chk("rr_cnt", det_cnt, 15);
            tick(); chk("rr_gap", gnt, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
